// File: rtl/wishbone_master_bridge.sv
// ---------------------------------------------------------------------------
// wishbone_master_bridge
//
// Turns each request the memory controller holds on its WB-side port into a
// single Wishbone classic read or write cycle. The core is stalled through
// wbBusy until the slave acks, the slave signals an error, or the optional
// timeout expires. A completion cycle then presents the read data.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   wbAddress  [27:0] : byte address offset from the controller
//   wbByteSelect [3:0]: byte lane enables
//   wbWriteEnable     : write request, held until wbBusy falls
//   wbReadEnable      : read request, held until wbBusy falls
//   wbDataWrite [31:0]: write data
//   wbDataRead [31:0] : registered read data (all ones after an error)
//   wbBusy            : core stall (combinational)
//   busError          : one-cycle pulse when a transaction ends in error
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o : bus outputs
//   wb_data_i, wb_ack_i, wb_err_i                               : bus inputs
// ---------------------------------------------------------------------------
module wishbone_master_bridge #(
    parameter logic [3:0]  ADDRESS_PREFIX = 4'b0001,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbWriteEnable,
    input  logic        wbReadEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        busError,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              timeout_hit;

    // Counter starts at 0 in the first ACTIVE cycle, so the bus cycle lasts
    // exactly TIMEOUT_CYCLES cycles before it is abandoned.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

    assign wbBusy = ((state_reg == ST_IDLE) && (wbReadEnable || wbWriteEnable))
                  || (state_reg == ST_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'h0;
            wb_adr_o   <= 32'h0;
            wb_data_o  <= 32'h0;
            wbDataRead <= 32'h0;
            busError   <= 1'b0;
        end else begin
            // busError is a pulse: only the transition into COMPLETE sets it.
            busError <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (wbWriteEnable || wbReadEnable) begin
                        wb_adr_o  <= {ADDRESS_PREFIX, wbAddress};
                        wb_sel_o  <= wbByteSelect;
                        wb_data_o <= wbDataWrite;
                        wb_we_o   <= wbWriteEnable;   // write wins over read
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        state_reg <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // Error beats ack; ack on the last timeout cycle beats timeout.
                    if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
                        wbDataRead <= 32'hFFFF_FFFF;
                        busError   <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        state_reg  <= ST_COMPLETE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            wbDataRead <= wb_data_i;
                        end
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        state_reg <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    cnt_reg   <= '0;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master_bridge.sv
module tb_wishbone_master_bridge;

    logic        clk;
    logic        rst_n;
    logic [27:0] wbAddress;
    logic [3:0]  wbByteSelect;
    logic        wbWriteEnable;
    logic        wbReadEnable;
    logic [31:0] wbDataWrite;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic        busError;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int passes = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    wishbone_master_bridge #(
        .ADDRESS_PREFIX (4'b0001),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wbAddress     (wbAddress),
        .wbByteSelect  (wbByteSelect),
        .wbWriteEnable (wbWriteEnable),
        .wbReadEnable  (wbReadEnable),
        .wbDataWrite   (wbDataWrite),
        .wbDataRead    (wbDataRead),
        .wbBusy        (wbBusy),
        .busError      (busError),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_adr_o      (wb_adr_o),
        .wb_data_o     (wb_data_o),
        .wb_data_i     (wb_data_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drives one request at a negedge and plays the slave. ack_at / err_at give
    // the ACTIVE-cycle index (0 = first) in which the slave responds, -1 = never.
    // Returns at the negedge of the COMPLETE cycle.
    task automatic do_txn(input string tag, input logic we, input logic re,
                          input logic [27:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input logic [31:0] sdata,
                          input int ack_at, input int err_at, input int exp_active,
                          input logic [31:0] exp_data, input logic exp_err,
                          input logic hold, input int exp_pre);
        int   busy_n;
        int   act;
        int   pre;
        logic done;
        exp_t e;
        wbWriteEnable = we;
        wbReadEnable  = re;
        wbAddress     = addr;
        wbByteSelect  = sel;
        wbDataWrite   = wdata;
        wb_data_i     = sdata;
        sb.push_back('{exp_data, exp_err});
        #1;
        busy_n = wbBusy ? 1 : 0;
        act = 0;
        pre = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (wbBusy) busy_n++;
            if (wb_cyc_o) begin
                chk({tag, "_adr"}, wb_adr_o, {4'b0001, addr});
                if (act == 0) begin
                    chk({tag, "_stb"}, {31'b0, wb_stb_o}, 32'd1);
                    chk({tag, "_we"}, {31'b0, wb_we_o}, {31'b0, we});
                    chk({tag, "_sel"}, {28'b0, wb_sel_o}, {28'b0, sel});
                    chk({tag, "_dato"}, wb_data_o, wdata);
                end
                wb_ack_i = (act == ack_at);
                wb_err_i = (act == err_at);
                act++;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                if (act > 0) begin
                    done = 1'b1;
                    chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk({tag, "_rdata"}, wbDataRead, e.data);
                        chk({tag, "_buserr"}, {31'b0, busError}, {31'b0, e.err});
                    end
                    chk({tag, "_busy_complete"}, {31'b0, wbBusy}, 32'd0);
                    if (!hold) begin
                        wbWriteEnable = 1'b0;
                        wbReadEnable  = 1'b0;
                    end
                end else begin
                    pre++;
                end
            end
        end
        chk({tag, "_completed"}, {31'b0, done}, 32'd1);
        chk({tag, "_active_cycles"}, 32'(act), 32'(exp_active));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(1 + exp_active));
        chk({tag, "_gap"}, 32'(pre), 32'(exp_pre));
        $display("txn %s: active=%0d busy=%0d rdata=%h busError=%0b", tag, act, busy_n, wbDataRead, busError);
    endtask

    // One cycle after COMPLETE: pulse gone, bus idle, core released.
    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_err_pulse_end"}, {31'b0, busError}, 32'd0);
        chk({tag, "_cyc_idle"}, {31'b0, wb_cyc_o}, 32'd0);
        chk({tag, "_busy_idle"}, {31'b0, wbBusy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wbAddress = '0; wbByteSelect = '0; wbWriteEnable = 1'b0; wbReadEnable = 1'b0;
        wbDataWrite = '0; wb_data_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_rdata", wbDataRead, 32'h0);
        chk("rst_buserr", {31'b0, busError}, 32'd0);
        chk("rst_busy", {31'b0, wbBusy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read with one wait state.
        do_txn("rd_wait", 1'b0, 1'b1, 28'h0000010, 4'hF, 32'h0, 32'hDEADBEEF,
               1, -1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        idle_check("rd_wait");

        // Zero-wait write; read data register must not change.
        do_txn("wr_zw", 1'b1, 1'b0, 28'h0000ABC, 4'b0011, 32'h12345678, 32'h11111111,
               0, -1, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        idle_check("wr_zw");

        // Error and ack together: error wins.
        do_txn("rd_err_ack", 1'b0, 1'b1, 28'h0000020, 4'hF, 32'h0, 32'h55555555,
               0, 0, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        idle_check("rd_err_ack");

        // Ack on the last timeout cycle wins.
        do_txn("rd_ack_last", 1'b0, 1'b1, 28'h0000030, 4'hF, 32'h0, 32'hCAFEF00D,
               3, -1, 4, 32'hCAFEF00D, 1'b0, 1'b0, 0);
        idle_check("rd_ack_last");

        // No response: timeout after 4 ACTIVE cycles.
        do_txn("rd_timeout", 1'b0, 1'b1, 28'h0000034, 4'hF, 32'h0, 32'hA5A5A5A5,
               -1, -1, 4, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        idle_check("rd_timeout");

        // Both enables: write is issued.
        do_txn("both_en", 1'b1, 1'b1, 28'h0000040, 4'hF, 32'h0BADF00D, 32'h22222222,
               0, -1, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        idle_check("both_en");

        // Byte select of zero still runs a bus cycle.
        do_txn("sel_zero", 1'b1, 1'b0, 28'h0000044, 4'h0, 32'h33333333, 32'h0,
               0, -1, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        idle_check("sel_zero");

        // Reset during ACTIVE aborts without a completion.
        wbReadEnable = 1'b1;
        wbAddress    = 28'h0000060;
        wbByteSelect = 4'hF;
        @(negedge clk);
        chk("rst_mid_active_cyc", {31'b0, wb_cyc_o}, 32'd1);
        wbReadEnable = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_mid_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_mid_adr", wb_adr_o, 32'h0);
        chk("rst_mid_sel", {28'b0, wb_sel_o}, 32'd0);
        chk("rst_mid_rdata", wbDataRead, 32'h0);
        chk("rst_mid_buserr", {31'b0, busError}, 32'd0);
        chk("rst_mid_busy", {31'b0, wbBusy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
            chk("post_rst_buserr", {31'b0, busError}, 32'd0);
        end
        $display("txn rst_abort: cyc=%0b rdata=%h", wb_cyc_o, wbDataRead);

        // Back-to-back: enables held through COMPLETE start a second cycle
        // after exactly two cyc-low cycles (COMPLETE + IDLE).
        do_txn("b2b_first", 1'b0, 1'b1, 28'h0000050, 4'hF, 32'h0, 32'h01020304,
               0, -1, 1, 32'h01020304, 1'b0, 1'b1, 0);
        do_txn("b2b_second", 1'b0, 1'b1, 28'h0000050, 4'hF, 32'h0, 32'h05060708,
               1, -1, 2, 32'h05060708, 1'b0, 1'b0, 1);
        idle_check("b2b");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
